// File: rtl/apb_reg_slave_pkg.sv
// apb_reg_slave_pkg: shared types, widths and the strobe-to-byte-mask helper.
package apb_reg_slave_pkg;

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    function automatic logic [DATA_W-1:0] strb2mask(input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < STRB_W; i++) m[8*i +: 8] = {8{strb[i]}};
        return m;
    endfunction

endpackage

// File: rtl/apb_wait_fsm.sv
// apb_wait_fsm: APB IDLE/ACCESS sequencing with programmable wait states.
// Ports: clk, rst (async, active-high); psel, penable from the bus;
// start pulses on the setup edge, pready is the completer ready, commit
// pulses in the completion cycle. Dropping psel during ACCESS aborts.
module apb_wait_fsm
    import apb_reg_slave_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic psel,
    input  logic penable,
    output logic start,
    output logic pready,
    output logic commit
);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        start    = 1'b0;
        pready   = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (psel) begin
                    state_nx = ACCESS;
                    cnt_nx   = 4'(WAIT_CYCLES);
                    start    = 1'b1;
                end
            end
            ACCESS: begin
                pready = (cnt == 4'd0);
                if (!psel) state_nx = IDLE;
                else if (penable && pready) begin
                    state_nx = IDLE;
                    commit   = 1'b1;
                end else if (cnt != 4'd0) cnt_nx = cnt - 4'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB4 completer with NUM_RW RW registers, RO status and W1C pending.
// Ports: pclk_i/preset_i clock and async active-high reset; psel_i, penable_i,
// pwrite_i, paddr_i, pwdata_i, pstrb_i, prdata_o, pready_o, pslverr_o form the
// APB completer side; sts_i is the live status word, irq_set_i sets pending
// bits, reg_o exposes the RW registers (reg k at [32k+31:32k]), irq_o is the
// registered OR of all pending bits.
module apb_reg_slave
    import apb_reg_slave_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int NUM_RW      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                     pclk_i,
    input  logic                     preset_i,
    input  logic                     psel_i,
    input  logic                     penable_i,
    input  logic                     pwrite_i,
    input  logic [ADDR_WIDTH-1:0]    paddr_i,
    input  logic [DATA_W-1:0]        pwdata_i,
    input  logic [STRB_W-1:0]        pstrb_i,
    output logic [DATA_W-1:0]        prdata_o,
    output logic                     pready_o,
    output logic                     pslverr_o,
    input  logic [DATA_W-1:0]        sts_i,
    input  logic [DATA_W-1:0]        irq_set_i,
    output logic [NUM_RW*DATA_W-1:0] reg_o,
    output logic                     irq_o
);

    localparam int IW = ADDR_WIDTH - 2;

    logic              start, pready, commit;
    logic [IW-1:0]     idx, idx_q;
    logic              is_rw, is_sts, is_pnd, dec_err;
    logic              write_q, err_q, rw_q, sts_q, pnd_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] strb_q;
    logic [DATA_W-1:0] regs [NUM_RW];
    logic [DATA_W-1:0] pending, pending_nx, clr, mask, rw_rd;
    logic              wr_ok;

    apb_wait_fsm #(.WAIT_CYCLES(WAIT_CYCLES)) u_fsm (
        .clk    (pclk_i),
        .rst    (preset_i),
        .psel   (psel_i),
        .penable(penable_i),
        .start  (start),
        .pready (pready),
        .commit (commit)
    );

    assign idx     = paddr_i[ADDR_WIDTH-1:2];
    assign is_rw   = idx < IW'(NUM_RW);
    assign is_sts  = idx == IW'(NUM_RW);
    assign is_pnd  = idx == IW'(NUM_RW + 1);
    assign dec_err = (|paddr_i[1:0]) | ~(is_rw | is_sts | is_pnd) | (pwrite_i & is_sts);

    // Transfer attributes are frozen at the setup edge so later bus changes cannot alter them.
    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            rw_q    <= 1'b0;
            sts_q   <= 1'b0;
            pnd_q   <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if (start) begin
            idx_q   <= idx;
            write_q <= pwrite_i;
            err_q   <= dec_err;
            rw_q    <= is_rw;
            sts_q   <= is_sts;
            pnd_q   <= is_pnd;
            wdata_q <= pwdata_i;
            strb_q  <= pstrb_i;
        end
    end

    assign mask  = strb2mask(strb_q);
    assign wr_ok = commit & write_q & ~err_q;

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            for (int k = 0; k < NUM_RW; k++) regs[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_RW; k++)
                if (wr_ok && rw_q && idx_q == IW'(k)) regs[k] <= (regs[k] & ~mask) | (wdata_q & mask);
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_reg
        assign reg_o[DATA_W*g +: DATA_W] = regs[g];
    end

    // New set pulses override a simultaneous W1C on the same bit.
    assign clr        = (wr_ok && pnd_q) ? (wdata_q & mask) : '0;
    assign pending_nx = (pending & ~clr) | irq_set_i;

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            pending <= '0;
            irq_o   <= 1'b0;
        end else begin
            pending <= pending_nx;
            irq_o   <= |pending_nx;
        end
    end

    always_comb begin
        rw_rd = '0;
        for (int k = 0; k < NUM_RW; k++)
            if (idx_q == IW'(k)) rw_rd = regs[k];
    end

    assign pready_o  = pready;
    assign pslverr_o = err_q & pready;
    assign prdata_o  = (pready && !write_q && !err_q) ? (rw_q ? rw_rd : sts_q ? sts_i : pending) : '0;

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb_apb_reg_slave: directed and random APB traffic against three wait-state variants.
module tb_apb_reg_slave;

    localparam int NR = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata, sts, irq_set;
    logic [3:0]  pstrb;
    int          sel;

    logic [31:0]      prdata [3];
    logic             pready [3];
    logic             pslverr[3];
    logic             irq    [3];
    logic [NR*32-1:0] rego   [3];

    int total = 0;
    int bad   = 0;

    logic [31:0] mreg [3][NR];
    logic [31:0] mpend[3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_reg_slave #(
            .ADDR_WIDTH (12),
            .NUM_RW     (NR),
            .WAIT_CYCLES(g == 0 ? 1 : g == 1 ? 3 : 0)
        ) dut (
            .pclk_i   (clk),
            .preset_i (rst),
            .psel_i   (psel && sel == g),
            .penable_i(penable),
            .pwrite_i (pwrite),
            .paddr_i  (paddr),
            .pwdata_i (pwdata),
            .pstrb_i  (pstrb),
            .prdata_o (prdata[g]),
            .pready_o (pready[g]),
            .pslverr_o(pslverr[g]),
            .sts_i    (sts),
            .irq_set_i(irq_set),
            .reg_o    (rego[g]),
            .irq_o    (irq[g])
        );
    end

    function automatic int wc(input int d);
        return d == 0 ? 1 : d == 1 ? 3 : 0;
    endfunction

    function automatic logic [NR*32-1:0] mpack(input int d);
        logic [NR*32-1:0] r;
        for (int k = 0; k < NR; k++) r[32*k +: 32] = mreg[d][k];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            mpend[d] = '0;
            for (int k = 0; k < NR; k++) mreg[d][k] = '0;
        end
    endtask

    task automatic apb(input int d, input bit wr, input logic [11:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input logic [31:0] s,
                       output logic [31:0] rd, output logic err, output int cyc);
        @(negedge clk);
        sel = d; psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = a; pwdata = wd; pstrb = st; irq_set = s;
        @(negedge clk);
        penable = 1'b1;
        cyc = 2;
        while (!pready[d] && cyc < 40) begin
            if (!wr) chk("prdata_not_ready", prdata[d], 0);
            @(negedge clk);
            cyc++;
        end
        rd  = prdata[d];
        err = pslverr[d];
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0; irq_set = '0;
    endtask

    task automatic xfer(input int d, input bit wr, input logic [11:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] s);
        logic [31:0] rd, erd, m;
        logic        err, eerr;
        int          cyc, idx;
        idx  = int'(a[11:2]);
        eerr = (a[1:0] != 2'b00) || idx > NR + 1 || (wr && idx == NR);
        m    = '0;
        for (int i = 0; i < 4; i++) if (st[i]) m[8*i +: 8] = 8'hFF;
        erd = eerr ? 32'h0 : idx < NR ? mreg[d][idx] : idx == NR ? sts : (mpend[d] | s);
        apb(d, wr, a, wd, st, s, rd, err, cyc);
        for (int k = 0; k < 3; k++) mpend[k] |= s;
        if (wr && !eerr) begin
            if (idx < NR) mreg[d][idx] = (mreg[d][idx] & ~m) | (wd & m);
            else mpend[d] = (mpend[d] & ~(wd & m)) | s;
        end
        chk("cycles", cyc, 2 + wc(d));
        chk("pslverr", err, eerr);
        if (!wr) chk("prdata", rd, erd);
        chk("reg_o", rego[d], mpack(d));
        chk("irq_o", irq[d], |mpend[d]);
    endtask

    initial begin
        logic [31:0] s;
        logic [9:0]  ridx;
        logic [1:0]  lo;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; sel = 0;
        paddr = '0; pwdata = '0; pstrb = '0; sts = 32'h5A5A_0001; irq_set = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pready", pready[0], 0);
        chk("rst_pslverr", pslverr[0], 0);
        chk("rst_prdata", prdata[0], 0);
        chk("rst_irq", irq[0], 0);
        chk("rst_reg_o", rego[0], 0);

        xfer(0, 1, 12'h004, 32'hDEADBEEF, 4'hF, 0);
        chk("reg1_full", rego[0][63:32], 32'hDEADBEEF);
        xfer(0, 1, 12'h004, 32'h11223344, 4'h5, 0);
        chk("reg1_partial", rego[0][63:32], 32'hDE22BE44);
        xfer(0, 0, 12'h004, 0, 4'h0, 0);

        xfer(0, 0, 12'h002, 0, 4'h0, 0);
        xfer(0, 1, 12'h020, 32'hFFFFFFFF, 4'hF, 0);
        xfer(0, 0, 12'h030, 0, 4'h0, 0);
        xfer(0, 0, 12'h020, 0, 4'h0, 0);

        @(negedge clk) irq_set = 32'h5;
        @(negedge clk) irq_set = 32'h0;
        for (int k = 0; k < 3; k++) mpend[k] |= 32'h5;
        chk("irq_after_set", irq[0], 1);
        xfer(0, 1, 12'h024, 32'h1, 4'hF, 32'h1);
        xfer(0, 0, 12'h024, 0, 4'h0, 0);
        chk("pend_set_wins", mpend[0], 32'h5);
        xfer(0, 1, 12'h024, 32'h5, 4'hF, 0);
        xfer(0, 0, 12'h024, 0, 4'h0, 0);
        chk("irq_cleared", irq[0], 0);

        xfer(1, 1, 12'h008, 32'h0BAD_CAFE, 4'hF, 0);
        @(negedge clk);
        sel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h008; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
        @(negedge clk) penable = 1'b1;
        @(negedge clk) begin psel = 1'b0; penable = 1'b0; end
        @(negedge clk);
        chk("abort_pready", pready[1], 0);
        chk("abort_reg", rego[1], mpack(1));
        xfer(1, 0, 12'h008, 0, 4'h0, 0);

        for (int k = 0; k < 4; k++) xfer(2, 1, 12'(4 * k), 32'(k + 1), 4'hF, 0);
        chk("b2b_regs", rego[2][127:0], {32'd4, 32'd3, 32'd2, 32'd1});

        for (int n = 0; n < 60; n++) begin
            ridx = 10'($urandom_range(0, NR + 3));
            lo   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            s    = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'h0;
            sts  = 32'($urandom);
            xfer($urandom_range(0, 2), 1'($urandom_range(0, 1)), {ridx, lo},
                 32'($urandom), 4'($urandom), s);
        end

        @(negedge clk) irq_set = 32'h80;
        @(negedge clk) irq_set = 32'h0;
        @(negedge clk);
        sel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h004;
        @(negedge clk) penable = 1'b1;
        @(negedge clk);
        chk("pre_rst_ready", pready[0], 1);
        chk("pre_rst_irq", irq[0], 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_pready", pready[0], 0);
        chk("mid_rst_pslverr", pslverr[0], 0);
        chk("mid_rst_prdata", prdata[0], 0);
        chk("mid_rst_irq", irq[0], 0);
        chk("mid_rst_reg_o", rego[0], 0);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; rst = 1'b0;
        model_reset();
        xfer(0, 0, 12'h004, 0, 4'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
